// File: rtl/stream_comparer_pkg.sv
// rtl/stream_comparer_pkg.sv - FSM/plane types and YUV420 frame geometry helpers
package stream_comparer_pkg;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;
  typedef enum logic [1:0] {PLANE_Y, PLANE_U, PLANE_V} plane_e;

  localparam int CNT_W = 32;

  function automatic int frame_len(input int w, input int h);
    return w * h * 3 / 2;
  endfunction

  function automatic int y_end(input int w, input int h);
    return w * h;
  endfunction

  function automatic int u_end(input int w, input int h);
    return w * h * 5 / 4;
  endfunction

  function automatic plane_e plane_of(input int idx, input int w, input int h);
    if (idx < y_end(w, h)) return PLANE_Y;
    if (idx < u_end(w, h)) return PLANE_U;
    return PLANE_V;
  endfunction

endpackage

// File: rtl/lane_cmp.sv
// rtl/lane_cmp.sv - one-lane absolute-difference compare against a tolerance
module lane_cmp #(
  parameter int DATA_W = 8,
  parameter int TOL    = 0
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              mis
);

  localparam int unsigned TOL_U = TOL;

  logic [DATA_W-1:0] diff;

  // Subtract the smaller from the larger so the difference never wraps.
  always_comb begin
    diff = (a >= b) ? (a - b) : (b - a);
    mis  = (32'(diff) > TOL_U);
  end

endmodule

// File: rtl/stream_comparer.sv
// rtl/stream_comparer.sv - compares two YUV420 element streams frame by frame
module stream_comparer
  import stream_comparer_pkg::*;
#(
  parameter  int DATA_W    = 8,
  parameter  int LANES     = 1,
  parameter  int FRAME_W   = 1280,
  parameter  int FRAME_H   = 720,
  parameter  int TOL       = 0,
  localparam int FRAME_LEN = frame_len(FRAME_W, FRAME_H),
  localparam int ADDR_W    = $clog2(FRAME_LEN + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    a_valid,
  input  logic [LANES*DATA_W-1:0] a_data,
  output logic                    a_ready,
  input  logic                    b_valid,
  input  logic [LANES*DATA_W-1:0] b_data,
  output logic                    b_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [CNT_W-1:0]        err_cnt,
  output logic [CNT_W-1:0]        err_y,
  output logic [CNT_W-1:0]        err_u,
  output logic [CNT_W-1:0]        err_v,
  output logic [ADDR_W-1:0]       first_err_addr,
  output logic                    first_err_vld,
  output logic                    mis_valid,
  output logic [ADDR_W-1:0]       mis_addr,
  output logic [LANES-1:0]        mis_mask,
  output logic [LANES*DATA_W-1:0] mis_a,
  output logic [LANES*DATA_W-1:0] mis_b
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - LANES);
  localparam logic [ADDR_W-1:0] IDX_STEP = ADDR_W'(LANES);
  localparam int                PC_W     = $clog2(LANES + 1);

  // Chroma planes must split on beat boundaries so each beat belongs to one plane.
  if ((FRAME_W * FRAME_H / 4) % LANES != 0) begin : g_bad_lanes
    $error("stream_comparer: FRAME_W*FRAME_H/4 must be a multiple of LANES");
  end

  function automatic logic [PC_W-1:0] popcount(input logic [LANES-1:0] m);
    logic [PC_W-1:0] n;
    n = '0;
    for (int k = 0; k < LANES; k++) n = n + PC_W'(m[k]);
    return n;
  endfunction

  function automatic int lowest_lane(input logic [LANES-1:0] m);
    int low;
    low = 0;
    for (int k = LANES - 1; k >= 0; k--) if (m[k]) low = k;
    return low;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c,
                                               input logic [PC_W-1:0]  n);
    logic [CNT_W:0] s;
    s = {1'b0, c} + (CNT_W + 1)'(n);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       idx_q, idx_d;
  logic                    mis_valid_q, mis_valid_d;
  logic [ADDR_W-1:0]       mis_addr_q, mis_addr_d;
  logic [LANES-1:0]        mis_mask_q, mis_mask_d;
  logic [LANES*DATA_W-1:0] mis_a_q, mis_a_d, mis_b_q, mis_b_d;
  plane_e                  mis_plane_q, mis_plane_d;
  logic [CNT_W-1:0]        err_cnt_q, err_cnt_d, err_y_q, err_y_d;
  logic [CNT_W-1:0]        err_u_q, err_u_d, err_v_q, err_v_d;
  logic [ADDR_W-1:0]       first_err_addr_q, first_err_addr_d;
  logic                    first_err_vld_q, first_err_vld_d;

  logic [LANES-1:0]        lane_mis;
  logic                    accept;
  logic [PC_W-1:0]         mis_cnt;
  int                      low_lane;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    lane_cmp #(
      .DATA_W(DATA_W),
      .TOL   (TOL)
    ) u_lane_cmp (
      .a  (a_data[k*DATA_W +: DATA_W]),
      .b  (b_data[k*DATA_W +: DATA_W]),
      .mis(lane_mis[k])
    );
  end

  // Ready is gated by rst so a beat offered during reset is never handshaken.
  assign accept = (state_q == S_RUN) && a_valid && b_valid && !rst;

  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    mis_valid_d      = 1'b0;
    mis_addr_d       = mis_addr_q;
    mis_mask_d       = mis_mask_q;
    mis_a_d          = mis_a_q;
    mis_b_d          = mis_b_q;
    mis_plane_d      = mis_plane_q;
    err_cnt_d        = err_cnt_q;
    err_y_d          = err_y_q;
    err_u_d          = err_u_q;
    err_v_d          = err_v_q;
    first_err_addr_d = first_err_addr_q;
    first_err_vld_d  = first_err_vld_q;
    mis_cnt          = popcount(mis_mask_q);
    low_lane         = lowest_lane(mis_mask_q);

    if (accept) begin
      mis_valid_d = |lane_mis;
      mis_addr_d  = idx_q;
      mis_mask_d  = lane_mis;
      mis_a_d     = a_data;
      mis_b_d     = b_data;
      mis_plane_d = plane_of(32'(idx_q), FRAME_W, FRAME_H);
    end

    if (mis_valid_q) begin
      err_cnt_d = sat_add(err_cnt_q, mis_cnt);
      case (mis_plane_q)
        PLANE_Y: err_y_d = sat_add(err_y_q, mis_cnt);
        PLANE_U: err_u_d = sat_add(err_u_q, mis_cnt);
        default: err_v_d = sat_add(err_v_q, mis_cnt);
      endcase
      if (!first_err_vld_q) begin
        first_err_vld_d  = 1'b1;
        first_err_addr_d = mis_addr_q + ADDR_W'(low_lane);
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d          = S_RUN;
          idx_d            = '0;
          err_cnt_d        = '0;
          err_y_d          = '0;
          err_u_d          = '0;
          err_v_d          = '0;
          first_err_vld_d  = 1'b0;
          first_err_addr_d = '0;
        end
      end
      S_RUN: begin
        if (accept) begin
          idx_d = idx_q + IDX_STEP;
          if (idx_q == LAST_IDX) state_d = S_DRAIN;
        end
      end
      S_DRAIN: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      idx_q            <= '0;
      mis_valid_q      <= 1'b0;
      mis_addr_q       <= '0;
      mis_mask_q       <= '0;
      mis_a_q          <= '0;
      mis_b_q          <= '0;
      mis_plane_q      <= PLANE_Y;
      err_cnt_q        <= '0;
      err_y_q          <= '0;
      err_u_q          <= '0;
      err_v_q          <= '0;
      first_err_addr_q <= '0;
      first_err_vld_q  <= 1'b0;
    end else begin
      state_q          <= state_d;
      idx_q            <= idx_d;
      mis_valid_q      <= mis_valid_d;
      mis_addr_q       <= mis_addr_d;
      mis_mask_q       <= mis_mask_d;
      mis_a_q          <= mis_a_d;
      mis_b_q          <= mis_b_d;
      mis_plane_q      <= mis_plane_d;
      err_cnt_q        <= err_cnt_d;
      err_y_q          <= err_y_d;
      err_u_q          <= err_u_d;
      err_v_q          <= err_v_d;
      first_err_addr_q <= first_err_addr_d;
      first_err_vld_q  <= first_err_vld_d;
    end
  end

  assign a_ready        = accept;
  assign b_ready        = accept;
  assign busy           = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done           = (state_q == S_DONE);
  assign pass           = done && (err_cnt_q == '0);
  assign err_cnt        = err_cnt_q;
  assign err_y          = err_y_q;
  assign err_u          = err_u_q;
  assign err_v          = err_v_q;
  assign first_err_addr = first_err_addr_q;
  assign first_err_vld  = first_err_vld_q;
  assign mis_valid      = mis_valid_q;
  assign mis_addr       = mis_addr_q;
  assign mis_mask       = mis_mask_q;
  assign mis_a          = mis_a_q;
  assign mis_b          = mis_b_q;

endmodule

// File: doc/stream_comparer.md
STREAM_COMPARER -- requirements
Module: stream_comparer

Interface
REQ-001 Parameter DATA_W, default 8, element width in bits.
REQ-002 Parameter LANES, default 1, elements per beat.
REQ-003 Parameter FRAME_W, default 1280, luma width in elements.
REQ-004 Parameter FRAME_H, default 720, luma height in elements.
REQ-005 Parameter TOL, default 0, maximum allowed absolute difference per element.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 rst  in  1  reset; synchronous, active-high.
REQ-008 start  in  1  one-cycle pulse; arms comparison of one frame.
REQ-009 a_valid  in  1 / a_data  in  LANES*DATA_W / a_ready  out  1  stream A; lane 0 in the LSBs.
REQ-010 b_valid  in  1 / b_data  in  LANES*DATA_W / b_ready  out  1  stream B.
REQ-011 busy  out  1  high in RUN and DRAIN.
REQ-012 done  out  1  high in DONE.
REQ-013 pass  out  1  done && err_cnt==0.
REQ-014 err_cnt, err_y, err_u, err_v  out  32 each  total and per-plane mismatching-element counts.
REQ-015 first_err_addr  out  ADDR_W / first_err_vld  out  1  element index of the first mismatch.
REQ-016 mis_valid  out  1 / mis_addr  out  ADDR_W / mis_mask  out  LANES / mis_a, mis_b  out  LANES*DATA_W  per-beat mismatch event.

Function
REQ-017 FRAME_LEN = FRAME_W*FRAME_H*3/2 (YUV420 planar); ADDR_W = clog2(FRAME_LEN+1); elaboration SHALL fail unless (FRAME_W*FRAME_H/4) % LANES == 0.
REQ-018 Plane by element index i: Y if i < W*H; U if i < W*H*5/4; otherwise V.
REQ-019 FSM states IDLE, RUN, DRAIN, DONE; IDLE --start--> RUN; RUN --last beat accepted--> DRAIN; DRAIN --1 cycle--> DONE; DONE --start--> RUN.
REQ-020 start in RUN or DRAIN SHALL be ignored; start in IDLE or DONE SHALL clear all counters, first_err_vld and the element index.
REQ-021 a_ready = b_ready = (state==RUN) && a_valid && b_valid; a beat is accepted only when both streams are valid.
REQ-022 Element index starts at 0 and advances by LANES per accepted beat; the beat with index FRAME_LEN-LANES is the last.
REQ-023 Lane k mismatches iff |a_k - b_k| > TOL, computed on DATA_W-bit unsigned values without wrap.
REQ-024 Stage 1 registers the accepted beat: mis_valid = 1 exactly one cycle after acceptance iff any lane mismatched, carrying the beat base index, lane mask and both data words.
REQ-025 Counters SHALL update from stage 1 one cycle later by popcount(mis_mask) and SHALL saturate at 2^32-1.
REQ-026 first_err_addr = base index + lowest set lane of the first mismatching beat; it is captured once per frame.
REQ-027 done and the final counters SHALL be valid together, two cycles after the last beat is accepted.
REQ-028 DONE holds all results stable until start or rst.

Reset
REQ-029 rst SHALL return the FSM to IDLE and zero every output, counter, stage-1 register and the element index, including mid-frame.
REQ-030 Beats presented during or in the cycle of rst SHALL NOT be accepted.

Structure
REQ-031 Package stream_comparer_pkg SHALL hold the FSM state enum, the plane enum (Y, U, V) and the FRAME_LEN and plane-boundary constant functions.
REQ-032 Per-lane abs-diff/TOL compare SHALL be sub-module lane_cmp, instantiated LANES times.

Verification (FRAME_W=8, FRAME_H=4, LANES=4: FRAME_LEN=48, 12 beats; Y 0-31, U 32-39, V 40-47)
REQ-033 Identical streams, both valid continuously after start -> 12 beats accepted, done 2 cycles after the last, err_cnt=0, pass=1.
REQ-034 b element 37 differs (TOL=0) -> one mis_valid with mis_addr=36, mis_mask=4'b0010; err_cnt=1, err_u=1, err_y=err_v=0, first_err_addr=37, pass=0.
REQ-035 TOL=2: a=10,b=12 on element 5 -> no mismatch; a=10,b=13 on element 5 -> err_y=1.
REQ-036 b_valid toggling every cycle, a_valid constant -> ready only when both are valid, no beat lost or duplicated, results equal to REQ-033.
REQ-037 rst asserted after beat 5 -> all outputs 0 and state IDLE next cycle; a new start then compares a full 48-element frame from index 0.
REQ-038 start pulsed mid-RUN -> ignored; start pulsed in DONE -> counters cleared and the second frame counted independently.
